// File: rtl/mmss_timer_pkg.sv
// Shared types, constants and BCD helpers for the mm:ss timer.
package mmss_timer_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit;

  localparam bcd_digit SEC_MAX_TENS  = 4'd5;
  localparam bcd_digit SEC_MAX_UNITS = 4'd9;
  localparam bcd_digit BCD_MAX       = 4'd9;

  // Two-digit BCD increment; the full value wraps to 00 after reaching limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] limit);
    logic [7:0] res;
    if (val == limit) begin
      res = 8'h00;
    end else if (val[3:0] == BCD_MAX) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Two-digit BCD decrement; 00 wraps back to limit.
  function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] limit);
    logic [7:0] res;
    if (val == 8'h00) begin
      res = limit;
    end else if (val[3:0] == 4'd0) begin
      res = {val[7:4] - 4'd1, BCD_MAX};
    end else begin
      res = {val[7:4], val[3:0] - 4'd1};
    end
    return res;
  endfunction

  // True when {min,sec} sits on the end value for the current direction.
  function automatic logic at_terminal(input logic [15:0] mmss, input logic up,
                                       input logic [15:0] up_end);
    return up ? (mmss == up_end) : (mmss == 16'h0000);
  endfunction

endpackage

// File: rtl/mmss_timer_tick.sv
// Tick prescaler: divides clk by DIV while running, cleared whenever not running.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  // Free-running modulo-DIV counter, held at zero while cleared or idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/mmss_timer.sv
// Parametrised mm:ss timer with BCD digit outputs for the VGA digit renderer.
// Optional lap-hold display freeze is enabled by defining MMSS_TIMER_LAP_EN.
module mmss_timer
  import mmss_timer_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       forward,
  input  logic       inc_sec,
  input  logic       inc_min,
`ifdef MMSS_TIMER_LAP_EN
  input  logic       lap,
`endif
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic       tick,
  output logic       finish,
  output logic       running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [7:0]  MIN_LIM = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0]  SEC_LIM = {SEC_MAX_TENS, SEC_MAX_UNITS};
  localparam logic [15:0] UP_END  = {MIN_LIM, SEC_LIM};

  state_e     state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       tick_w;
  logic [15:0] live_w;
  logic [15:0] view_w;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != RUN),
    .run   (state_q == RUN),
    .tick  (tick_w)
  );

  // Next-state and next-digit logic: manual set in STOP, counting in RUN.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    case (state_q)
      STOP: begin
        if (inc_sec) begin
          sec_d = bcd_inc(sec_q, SEC_LIM);
        end
        if (inc_min) begin
          min_d = bcd_inc(min_q, MIN_LIM);
        end
        if (enable) begin
          state_d = at_terminal({min_d, sec_d}, forward, UP_END) ? DONE : RUN;
        end
      end
      RUN: begin
        if (tick_w) begin
          if (forward) begin
            sec_d = bcd_inc(sec_q, SEC_LIM);
            if (sec_q == SEC_LIM) begin
              min_d = bcd_inc(min_q, MIN_LIM);
            end
          end else begin
            sec_d = bcd_dec(sec_q, SEC_LIM);
            if (sec_q == 8'h00) begin
              min_d = bcd_dec(min_q, MIN_LIM);
            end
          end
          if (at_terminal({min_d, sec_d}, forward, UP_END)) begin
            state_d = DONE;
          end else if (!enable) begin
            state_d = STOP;
          end
        end else if (!enable) begin
          state_d = STOP;
        end
      end
      DONE: begin
        if (!enable) begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = STOP;
      end
    endcase
  end

  // State and digit registers; the digits are the counting state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STOP;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
    end
  end

  assign live_w = {min_q, sec_q};

`ifdef MMSS_TIMER_LAP_EN
  logic        lap_q;
  logic [15:0] snap_q;

  // Capture the live digits on the rising edge of lap and show them while lap stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_q  <= 1'b0;
      snap_q <= 16'h0000;
    end else begin
      lap_q <= lap;
      if (lap && !lap_q) begin
        snap_q <= live_w;
      end
    end
  end

  assign view_w = lap_q ? snap_q : live_w;
`else
  assign view_w = live_w;
`endif

  assign min_tens  = view_w[15:12];
  assign min_units = view_w[11:8];
  assign sec_tens  = view_w[7:4];
  assign sec_units = view_w[3:0];
  assign tick      = tick_w;
  assign finish    = (state_q == DONE);
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_mmss_timer.sv
// Self-checking bench for mmss_timer with CLK_HZ=10, TICK_HZ=1, MAX_MIN=2.
// Tick-driven digit updates are checked through an expected-value queue.
module tb_mmss_timer;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic forward;
  logic incSec;
  logic incMin;
  logic [3:0] secTens, secUnits, minTens, minUnits;
  logic tick, finish, running;
  logic [15:0] digits;
`ifdef MMSS_TIMER_LAP_EN
  logic lap = 1'b0;
`endif

  int compareCount = 0;
  int mismatchCount = 0;
  logic [16:0] expQ[$];
  logic [16:0] sbExp;
  logic tickPending = 1'b0;
  bit sbEnable = 1'b1;

  mmss_timer #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .MAX_MIN (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .forward   (forward),
    .inc_sec   (incSec),
    .inc_min   (incMin),
`ifdef MMSS_TIMER_LAP_EN
    .lap       (lap),
`endif
    .sec_tens  (secTens),
    .sec_units (secUnits),
    .min_tens  (minTens),
    .min_units (minUnits),
    .tick      (tick),
    .finish    (finish),
    .running   (running)
  );

  assign digits = {minTens, minUnits, secTens, secUnits};

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Single-cycle manual set pulse followed by an idle cycle.
  task automatic applyStimulus(input logic s, input logic m);
    incSec = s;
    incMin = m;
    @(negedge clk);
    incSec = 1'b0;
    incMin = 1'b0;
    @(negedge clk);
  endtask

  task automatic resetDut();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Counts clock edges from the RUN entry until the digits leave fromVal.
  task automatic measureLatency(input logic [15:0] fromVal, output int n);
    n = 0;
    for (int i = 0; i < 5 && !running; i++) @(negedge clk);
    while (digits == fromVal && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitFinish(input int limit);
    for (int i = 0; i < limit && !finish; i++) @(negedge clk);
  endtask

  // Scoreboard: a tick seen at one negedge means the digits changed by the next.
  always @(negedge clk) begin
    if (tickPending && sbEnable) begin
      if (expQ.size() == 0) begin
        checkOutput("sbUnexpectedTick", 32'(expQ.size()), 32'd1);
      end else begin
        sbExp = expQ.pop_front();
        checkOutput("sbDigits", {15'd0, finish, digits}, {15'd0, sbExp});
      end
    end
    tickPending = tick;
  end

  // Abort guard so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int sec;
    int min;
    logic fin;

    reset = 1'b0;
    enable = 1'b0;
    forward = 1'b1;
    incSec = 1'b0;
    incMin = 1'b0;
    @(negedge clk);
    checkOutput("resetDigits", 32'(digits), 32'h0000);
    checkOutput("resetFlags", {29'd0, tick, finish, running}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Count up 00:00 -> 02:59.
    sec = 0;
    min = 0;
    fin = 1'b0;
    while (!fin) begin
      sec++;
      if (sec == 60) begin
        sec = 0;
        min++;
      end
      fin = (min == 2 && sec == 59);
      expQ.push_back({fin, toBcd(min), toBcd(sec)});
    end
    forward = 1'b1;
    enable = 1'b1;
    measureLatency(16'h0000, n);
    checkOutput("upFirstTickLatency", 32'(n), 32'd10);
    for (int i = 0; i < 30 && !tick; i++) @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 30);
    checkOutput("upTickPeriod", 32'(n), 32'd10);
    waitFinish(2000);
    checkOutput("upDoneDigits", 32'(digits), 32'h0259);
    checkOutput("upDoneFlags", {30'd0, finish, running}, 32'b10);
    repeat (100) @(negedge clk);
    checkOutput("upDoneHold", {15'd0, finish, digits}, {15'd0, 1'b1, 16'h0259});
    enable = 1'b0;
    @(negedge clk);
    checkOutput("doneToStop", {30'd0, finish, running}, 32'd0);

    // Count down 01:00 -> 00:00.
    resetDut();
    applyStimulus(1'b0, 1'b1);
    checkOutput("setOneMinute", 32'(digits), 32'h0100);
    sec = 0;
    min = 1;
    fin = 1'b0;
    while (!fin) begin
      if (sec == 0) begin
        sec = 59;
        min--;
      end else begin
        sec--;
      end
      fin = (min == 0 && sec == 0);
      expQ.push_back({fin, toBcd(min), toBcd(sec)});
    end
    forward = 1'b0;
    enable = 1'b1;
    waitFinish(1000);
    checkOutput("downDone", {14'd0, finish, running, digits}, {14'd0, 2'b10, 16'h0000});
    enable = 1'b0;
    @(negedge clk);

    // Enable at the terminal value goes straight to DONE without a tick.
    enable = 1'b1;
    @(negedge clk);
    checkOutput("stopToDone", {30'd0, finish, running}, 32'b10);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("doneClear", {30'd0, finish, running}, 32'd0);

    // Manual set in STOP.
    for (int i = 0; i < 55; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("setSec55", 32'(digits), 32'h0055);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("secWrapNoCarry", 32'(digits), 32'h0002);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("setMin02", 32'(digits), 32'h0202);
    applyStimulus(1'b0, 1'b1);
    checkOutput("minWrap", 32'(digits), 32'h0002);
    applyStimulus(1'b0, 1'b1);
    checkOutput("minAfterWrap", 32'(digits), 32'h0102);
    applyStimulus(1'b1, 1'b1);
    checkOutput("bothPulses", 32'(digits), 32'h0203);

    // inc_sec ignored in RUN, then stop/restart resets the prescaler.
    forward = 1'b1;
    expQ.push_back({1'b0, 16'h0204});
    enable = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("incIgnoredInRun", 32'(digits), 32'h0203);
    for (int i = 0; i < 20 && digits != 16'h0204; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stopHold", {15'd0, running, digits}, {15'd0, 1'b0, 16'h0204});
    expQ.push_back({1'b0, 16'h0205});
    enable = 1'b1;
    measureLatency(16'h0204, n);
    checkOutput("reentryLatency", 32'(n), 32'd10);
    enable = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    resetDut();
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 23; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("set0123", 32'(digits), 32'h0123);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("runningBeforeReset", 32'(running), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncResetDigits", 32'(digits), 32'h0000);
    checkOutput("asyncResetFlags", {29'd0, tick, finish, running}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifdef MMSS_TIMER_LAP_EN
    // Lap hold freezes the displayed digits while counting continues.
    sbEnable = 1'b0;
    forward = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 200 && digits != 16'h0007; i++) @(negedge clk);
    lap = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("lapHold", {15'd0, running, digits}, {15'd0, 1'b1, 16'h0007});
    lap = 1'b0;
    @(negedge clk);
    checkOutput("lapRelease", 32'(digits), 32'h0010);
    enable = 1'b0;
    @(negedge clk);
`endif

    checkOutput("sbDrain", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
